multi_ball_collision_detector: RTL and testbench
================================================

Name: multi_ball_collision_detector

Overview:
- Parametrised successor to the single-ball collision detector, serving N_BALLS balls.
- Each ball has its own hit box. The block counts target-colour camera pixels inside each box over a whole frame.
- At frame end it judges each ball against a threshold, applies a per-ball frame cooldown, and reports a one-cycle collision pulse per ball with an estimated object speed.
- Sits between color_detector / VGA_Controller and game_controller / score_calculator in the 25 MHz pixel domain.

Parameters:
- N_BALLS, 4, number of independently tracked balls (1..8).
- BALL_SIZE, 32, hit box edge length in pixels (square box).
- HIT_THRESH, 16, minimum target pixels in a box per frame to declare a hit.
- COOLDOWN_FRAMES, 8, frames a ball stays blind after a hit (>=1).
- X_W, 10, pixel coordinate width.
- CNT_W, 11, per-ball pixel counter width (saturating).
- IDX_W, $clog2(N_BALLS) (min 1), width of the collision index.

Ports:
- clk_25MHz  in  1  pixel clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  game running; low = all balls held idle.
- x_pixel  in  X_W  current VGA x coordinate.
- y_pixel  in  X_W  current VGA y coordinate.
- DE  in  1  active-video qualifier.
- is_target_color  in  1  current pixel matches the target colour.
- frame_end  in  1  one-cycle pulse per frame, issued after the last active pixel.
- ball_valid  in  N_BALLS  ball i is on screen.
- ball_x  in  N_BALLS*X_W  packed left edges; ball i occupies bits [i*X_W +: X_W].
- ball_y  in  N_BALLS*X_W  packed top edges; same packing as ball_x.
- collision_detected  out  N_BALLS  one-cycle hit pulse per ball.
- collision_any  out  1  OR of collision_detected.
- collision_idx  out  IDX_W  lowest index pulsing this cycle; 0 if none.
- estimated_speed  out  N_BALLS*X_W  per-ball speed captured at the last hit; held until the next hit.

Behaviour:
- Reset values:
  - All outputs 0.
  - All counters 0.
  - min_x registers all-ones.
  - prev_valid 0.
  - All balls in ARMED.
- In-box test: ball_x <= x_pixel < ball_x+BALL_SIZE, and likewise for y.
  - Compute the sums in X_W+1 bits so there is no wrap at the screen edge.
  - The test also requires DE=1 and ball_valid[i]=1.
- Accumulate: while in-box and is_target_color, count[i] increments, saturating at all-ones. min_x[i] = min(min_x[i], x_pixel).
- frame_end cycle:
  - Evaluate every ball from the pre-update count and min_x values.
  - A qualifying pixel in the same cycle as frame_end belongs to the closing frame.
  - Afterwards, count[i] is cleared to 0 and min_x[i] is set to all-ones.
- Speed tracking at frame_end:
  - If count[i] > 0: prev_min_x[i] takes the frame's min_x and prev_valid[i] is set to 1.
  - Else: prev_valid[i] is cleared to 0.
- Per-ball FSM, evaluated only on frame_end:
  - ARMED -> HIT when ball_valid[i] and count[i] >= HIT_THRESH.
  - HIT lasts exactly one cycle. It drives collision_detected[i]=1 in the cycle after frame_end (latency 1), then moves to COOLDOWN with cd_cnt = COOLDOWN_FRAMES.
  - Speed captured on entering HIT:
    - estimated_speed[i] = |min_x - prev_min_x| if prev_valid[i], else 0.
    - prev_* here means the values before the frame_end update.
  - COOLDOWN: cd_cnt decrements on each frame_end and returns to ARMED on the frame_end where cd_cnt reaches 0.
  - Pixels are still counted during COOLDOWN but never produce a hit.
- Multiple balls may pulse in the same cycle. collision_idx reports the lowest index.
- enable low:
  - Counters and min_x hold their cleared values; prev_valid is cleared.
  - FSMs are forced to ARMED; no pulses are produced.
  - estimated_speed holds its last value.
- ball_valid low for ball i: ball i stops accumulating. Its FSM continues the cooldown countdown but cannot hit.
- Reset mid-frame: everything returns to reset values on the next edge, with no spurious pulse.
- HIT_THRESH=0 is illegal; guard it with an elaboration assertion.

Decomposition:
- Package mbcd_pkg holds:
  - Typedef coord_t (logic [X_W-1:0]).
  - The FSM enum ball_state_e {ARMED, HIT, COOLDOWN}.
  - A function abs_diff.
- Sub-module ball_hit_tracker contains one ball's in-box test, counter, min_x/prev tracking, FSM and speed register.
- The top level instantiates ball_hit_tracker via generate for N_BALLS and contains the priority encoder for collision_idx.

Test Plan:
- Single frame, 20 target pixels inside ball 0's box at (100,200), HIT_THRESH=16 -> collision_detected=4'b0001 one cycle after frame_end, collision_idx=0, collision_any=1.
- Only 15 target pixels inside the box -> no pulse. Counter cleared: the next frame with 0 pixels shows no carry-over.
- Hit on frame k, then 20 pixels every frame -> next pulse at frame k+COOLDOWN_FRAMES+1 (k+9), none earlier.
- Balls 1 and 3 both hit in the same frame -> collision_detected=4'b1010, collision_idx=1.
- Frame A has min_x=110, frame B has min_x=125 with a hit -> estimated_speed[i]=15. With no target pixels in the preceding frame -> 0.
- Ball box at x=620 with BALL_SIZE=32 (box crosses 639) -> no wrap-around hits at x<20. Mid-frame reset or enable=0 -> all outputs 0 and no pulse at frame_end.

Source files
------------

// File: rtl/mbcd_pkg.sv
// Shared types and helpers for the multi-ball collision detector.
package mbcd_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned DIFF_W  = 16;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ARMED,
        HIT,
        COOLDOWN
    } ball_state_e;

    function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] a,
                                                   input logic [DIFF_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/ball_hit_tracker.sv
// One ball: in-box pixel counting, leftmost-pixel tracking, hit/cooldown FSM and speed capture.
module ball_hit_tracker
    import mbcd_pkg::*;
#(
    parameter int unsigned BALL_SIZE       = 32,
    parameter int unsigned HIT_THRESH      = 16,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int unsigned X_W             = 10,
    parameter int unsigned CNT_W           = 11
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           enable_i,
    input  logic [X_W-1:0] x_i,
    input  logic [X_W-1:0] y_i,
    input  logic           de_i,
    input  logic           target_i,
    input  logic           frame_end_i,
    input  logic           valid_i,
    input  logic [X_W-1:0] box_x_i,
    input  logic [X_W-1:0] box_y_i,
    output logic           hit_o,
    output logic [X_W-1:0] speed_o
);

    localparam int unsigned CD_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CD_W-1:0] CD_INIT = CD_W'(COOLDOWN_FRAMES);
    localparam logic [X_W:0] SIZE = (X_W + 1)'(BALL_SIZE);

    logic             in_box;
    logic             qualify;
    logic             hit_now;
    logic [CNT_W-1:0] count_q, count_eff;
    logic [X_W-1:0]   min_x_q, min_x_eff;
    logic [X_W-1:0]   prev_min_x_q;
    logic             prev_valid_q;
    logic [X_W-1:0]   speed_q;
    logic [CD_W-1:0]  cd_q;
    ball_state_e      state_q;

    // Extra top bit keeps box_x+BALL_SIZE from wrapping past the screen edge.
    always_comb begin
        in_box = de_i && valid_i
              && ({1'b0, box_x_i} <= {1'b0, x_i}) && ({1'b0, x_i} < ({1'b0, box_x_i} + SIZE))
              && ({1'b0, box_y_i} <= {1'b0, y_i}) && ({1'b0, y_i} < ({1'b0, box_y_i} + SIZE));
        qualify   = in_box && target_i;
        count_eff = count_q;
        min_x_eff = min_x_q;
        if (qualify) begin
            if (count_q != '1) count_eff = count_q + 1'b1;
            if (x_i < min_x_q) min_x_eff = x_i;
        end
        hit_now = valid_i && (32'(count_eff) >= HIT_THRESH);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q      <= '0;
            min_x_q      <= '1;
            prev_min_x_q <= '0;
            prev_valid_q <= 1'b0;
            speed_q      <= '0;
            cd_q         <= '0;
            state_q      <= ARMED;
        end else if (!enable_i) begin
            count_q      <= '0;
            min_x_q      <= '1;
            prev_valid_q <= 1'b0;
            cd_q         <= '0;
            state_q      <= ARMED;
        end else begin
            if (frame_end_i) begin
                count_q <= '0;
                min_x_q <= '1;
                if (count_eff != '0) begin
                    prev_min_x_q <= min_x_eff;
                    prev_valid_q <= 1'b1;
                end else begin
                    prev_valid_q <= 1'b0;
                end
            end else begin
                count_q <= count_eff;
                min_x_q <= min_x_eff;
            end

            case (state_q)
                ARMED: begin
                    if (frame_end_i && hit_now) begin
                        state_q <= HIT;
                        speed_q <= prev_valid_q
                                 ? X_W'(abs_diff(DIFF_W'(min_x_eff), DIFF_W'(prev_min_x_q)))
                                 : '0;
                    end
                end
                HIT: begin
                    state_q <= COOLDOWN;
                    cd_q    <= CD_INIT;
                end
                COOLDOWN: begin
                    if (frame_end_i) begin
                        if (cd_q <= CD_W'(1)) begin
                            cd_q    <= '0;
                            state_q <= ARMED;
                        end else begin
                            cd_q <= cd_q - 1'b1;
                        end
                    end
                end
                default: state_q <= ARMED;
            endcase
        end
    end

    assign hit_o   = (state_q == HIT);
    assign speed_o = speed_q;

endmodule

// File: rtl/multi_ball_collision_detector.sv
// Per-frame target-pixel hit detection for N_BALLS balls with cooldown and speed estimate.
module multi_ball_collision_detector
    import mbcd_pkg::*;
#(
    parameter int unsigned N_BALLS         = 4,
    parameter int unsigned BALL_SIZE       = 32,
    parameter int unsigned HIT_THRESH      = 16,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int unsigned X_W             = 10,
    parameter int unsigned CNT_W           = 11,
    parameter int unsigned IDX_W           = (N_BALLS > 1) ? $clog2(N_BALLS) : 1
) (
    input  logic                   clk_25MHz,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [X_W-1:0]         x_pixel,
    input  logic [X_W-1:0]         y_pixel,
    input  logic                   DE,
    input  logic                   is_target_color,
    input  logic                   frame_end,
    input  logic [N_BALLS-1:0]     ball_valid,
    input  logic [N_BALLS*X_W-1:0] ball_x,
    input  logic [N_BALLS*X_W-1:0] ball_y,
    output logic [N_BALLS-1:0]     collision_detected,
    output logic                   collision_any,
    output logic [IDX_W-1:0]       collision_idx,
    output logic [N_BALLS*X_W-1:0] estimated_speed
);

    if (HIT_THRESH == 0) begin : g_bad_thresh
        $fatal(1, "multi_ball_collision_detector: HIT_THRESH must be nonzero");
    end

    for (genvar i = 0; i < N_BALLS; i++) begin : g_ball
        ball_hit_tracker #(
            .BALL_SIZE      (BALL_SIZE),
            .HIT_THRESH     (HIT_THRESH),
            .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
            .X_W            (X_W),
            .CNT_W          (CNT_W)
        ) u_tracker (
            .clk_i      (clk_25MHz),
            .rst_i      (reset),
            .enable_i   (enable),
            .x_i        (x_pixel),
            .y_i        (y_pixel),
            .de_i       (DE),
            .target_i   (is_target_color),
            .frame_end_i(frame_end),
            .valid_i    (ball_valid[i]),
            .box_x_i    (ball_x[i*X_W +: X_W]),
            .box_y_i    (ball_y[i*X_W +: X_W]),
            .hit_o      (collision_detected[i]),
            .speed_o    (estimated_speed[i*X_W +: X_W])
        );
    end

    assign collision_any = |collision_detected;

    // Scan downwards so the lowest pulsing index wins.
    always_comb begin
        collision_idx = '0;
        for (int i = N_BALLS - 1; i >= 0; i--) begin
            if (collision_detected[i]) collision_idx = IDX_W'(i);
        end
    end

endmodule

// File: tb/tb_multi_ball_collision_detector.sv
// Randomised self-checking bench with a frame-level reference model of ball hits.
module tb_multi_ball_collision_detector;

    localparam int N  = 4;
    localparam int XW = 10;
    localparam int BS = 32;
    localparam int TH = 16;
    localparam int CD = 8;
    localparam int IW = 2;
    localparam int CMAX = 2047;

    logic            clk = 1'b0;
    logic            reset, enable, DE, tgt, frame_end;
    logic [XW-1:0]   xp, yp;
    logic [N-1:0]    bvalid;
    logic [N*XW-1:0] bxp, byp;
    logic [N-1:0]    collision_detected;
    logic            collision_any;
    logic [IW-1:0]   collision_idx;
    logic [N*XW-1:0] estimated_speed;

    always #20 clk = ~clk;

    multi_ball_collision_detector #(
        .N_BALLS(N), .BALL_SIZE(BS), .HIT_THRESH(TH), .COOLDOWN_FRAMES(CD),
        .X_W(XW), .CNT_W(11), .IDX_W(IW)
    ) u_dut (
        .clk_25MHz         (clk),
        .reset             (reset),
        .enable            (enable),
        .x_pixel           (xp),
        .y_pixel           (yp),
        .DE                (DE),
        .is_target_color   (tgt),
        .frame_end         (frame_end),
        .ball_valid        (bvalid),
        .ball_x            (bxp),
        .ball_y            (byp),
        .collision_detected(collision_detected),
        .collision_any     (collision_any),
        .collision_idx     (collision_idx),
        .estimated_speed   (estimated_speed)
    );

    // Reference model: per-ball frame statistics and remaining blind frames.
    int m_bx[N], m_by[N], m_cnt[N], m_minx[N], m_prev[N], m_blind[N], m_speed[N];
    bit m_bv[N], m_prevv[N];
    int checks = 0, passed = 0;
    logic [N-1:0]  last_seen;
    logic [IW-1:0] last_idx;

    task automatic apply_balls();
        for (int i = 0; i < N; i++) begin
            bxp[i*XW +: XW] = XW'(m_bx[i]);
            byp[i*XW +: XW] = XW'(m_by[i]);
            bvalid[i]       = m_bv[i];
        end
    endtask

    task automatic set_ball(input int i, input int x, input int y, input bit v);
        m_bx[i] = x; m_by[i] = y; m_bv[i] = v;
        apply_balls();
    endtask

    task automatic model_clear(input bit keep_speed);
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_minx[i] = 1023; m_prevv[i] = 0; m_blind[i] = 0;
            if (!keep_speed) begin m_speed[i] = 0; m_prev[i] = 0; end
        end
    endtask

    task automatic pixel(input int x, input int y, input bit de, input bit t);
        xp = XW'(x); yp = XW'(y); DE = de; tgt = t;
        if (enable && !reset && de && t) begin
            for (int i = 0; i < N; i++) begin
                if (m_bv[i] && x >= m_bx[i] && x < m_bx[i] + BS
                        && y >= m_by[i] && y < m_by[i] + BS) begin
                    if (m_cnt[i] < CMAX) m_cnt[i]++;
                    if (x < m_minx[i]) m_minx[i] = x;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    // n target pixels in ball i's box with x drawn from [xlo, xhi].
    task automatic hit_pixels(input int i, input int n, input int xlo, input int xhi);
        for (int k = 0; k < n; k++)
            pixel(int'($urandom_range(xhi, xlo)), m_by[i] + int'($urandom_range(BS - 1, 0)), 1, 1);
    endtask

    task automatic end_frame(input string name);
        logic [N-1:0]    em;
        logic [N*XW-1:0] es;
        int ei;
        em = '0;
        xp = '0; yp = '0; DE = 0; tgt = 0; frame_end = 1;
        if (enable && !reset) begin
            for (int i = 0; i < N; i++) begin
                if (m_blind[i] > 0) m_blind[i]--;
                else if (m_bv[i] && m_cnt[i] >= TH) begin
                    em[i] = 1'b1;
                    m_speed[i] = !m_prevv[i] ? 0 :
                                 (m_minx[i] > m_prev[i]) ? m_minx[i] - m_prev[i]
                                                         : m_prev[i] - m_minx[i];
                    m_blind[i] = CD;
                end
                m_prevv[i] = (m_cnt[i] > 0);
                if (m_cnt[i] > 0) m_prev[i] = m_minx[i];
                m_cnt[i] = 0; m_minx[i] = 1023;
            end
        end
        ei = 0;
        for (int i = N - 1; i >= 0; i--) if (em[i]) ei = i;
        for (int i = 0; i < N; i++) es[i*XW +: XW] = XW'(m_speed[i]);
        @(posedge clk); #1;
        frame_end = 0;
        last_seen = collision_detected;
        last_idx  = collision_idx;
        checks += 4;
        if (collision_detected !== em)
            $display("FAIL %s pulse: got %b want %b", name, collision_detected, em);
        else passed++;
        if (collision_any !== (|em))
            $display("FAIL %s any: got %b want %b", name, collision_any, |em);
        else passed++;
        if (collision_idx !== IW'(ei))
            $display("FAIL %s idx: got %0d want %0d", name, collision_idx, ei);
        else passed++;
        if (estimated_speed !== es)
            $display("FAIL %s speed: got %h want %h", name, estimated_speed, es);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (collision_detected !== '0)
            $display("FAIL %s pulse_width: got %b want 0", name, collision_detected);
        else passed++;
    endtask

    task automatic rearm();
        enable = 0;
        model_clear(1);
        pixel(0, 0, 0, 0);
        enable = 1;
        for (int i = 0; i < N; i++) m_bv[i] = 0;
        apply_balls();
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if (collision_detected !== '0 || collision_any !== 1'b0 || collision_idx !== '0
                || estimated_speed !== '0)
            $display("FAIL %s outputs: got %b/%b/%0d/%h want all 0", name, collision_detected,
                     collision_any, collision_idx, estimated_speed);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1; enable = 1; DE = 0; tgt = 0; frame_end = 0; xp = '0; yp = '0;
        for (int i = 0; i < N; i++) begin m_bx[i] = 0; m_by[i] = 0; m_bv[i] = 0; end
        apply_balls();
        model_clear(0);
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        check_zero_outputs("reset");
    endtask

    task automatic test_single_hit();
        rearm();
        set_ball(0, 100, 200, 1);
        hit_pixels(0, 20, 100, 131);
        end_frame("single");
        checks++;
        if (last_seen !== 4'b0001 || last_idx !== 2'd0)
            $display("FAIL single_exact: got %b idx %0d want 0001 idx 0", last_seen, last_idx);
        else passed++;
    endtask

    task automatic test_below_thresh();
        rearm();
        set_ball(0, 100, 200, 1);
        hit_pixels(0, 15, 100, 131);
        end_frame("below");
        end_frame("carry");
        checks++;
        if (last_seen !== 4'b0000)
            $display("FAIL carry_exact: got %b want 0000", last_seen);
        else passed++;
    endtask

    task automatic test_cooldown();
        logic [10:0] seen, want;
        rearm();
        set_ball(0, 100, 200, 1);
        seen = '0;
        for (int f = 0; f < 11; f++) begin
            hit_pixels(0, 20, 100, 131);
            end_frame("cooldown");
            seen[f] = last_seen[0];
        end
        want = 11'b010_0000_0001;
        checks++;
        if (seen !== want) $display("FAIL cooldown_frames: got %b want %b", seen, want);
        else passed++;
    endtask

    task automatic test_multi();
        rearm();
        set_ball(0, 10, 10, 1);
        set_ball(1, 200, 100, 1);
        set_ball(2, 300, 10, 1);
        set_ball(3, 400, 300, 1);
        hit_pixels(1, 20, 200, 231);
        hit_pixels(3, 20, 400, 431);
        hit_pixels(0, 5, 10, 41);
        end_frame("multi");
        checks++;
        if (last_seen !== 4'b1010 || last_idx !== 2'd1)
            $display("FAIL multi_exact: got %b idx %0d want 1010 idx 1", last_seen, last_idx);
        else passed++;
    endtask

    task automatic test_speed();
        rearm();
        set_ball(2, 100, 50, 1);
        pixel(110, 60, 1, 1);
        hit_pixels(2, 4, 110, 131);
        end_frame("speed_a");
        pixel(125, 70, 1, 1);
        hit_pixels(2, 19, 125, 131);
        end_frame("speed_b");
        checks++;
        if (estimated_speed[2*XW +: XW] !== XW'(15))
            $display("FAIL speed_15: got %0d want 15", estimated_speed[2*XW +: XW]);
        else passed++;
        set_ball(1, 300, 300, 1);
        end_frame("speed_empty");
        hit_pixels(1, 20, 300, 331);
        end_frame("speed_zero");
        checks++;
        if (estimated_speed[1*XW +: XW] !== XW'(0))
            $display("FAIL speed_zero: got %0d want 0", estimated_speed[1*XW +: XW]);
        else passed++;
    endtask

    task automatic test_edge();
        rearm();
        set_ball(0, 620, 50, 1);
        hit_pixels(0, 25, 0, 19);
        end_frame("edge_wrap");
        checks++;
        if (last_seen !== 4'b0000) $display("FAIL edge_wrap_exact: got %b want 0000", last_seen);
        else passed++;
        hit_pixels(0, 20, 620, 639);
        end_frame("edge_inside");
    endtask

    task automatic test_reset_mid();
        rearm();
        set_ball(0, 100, 200, 1);
        hit_pixels(0, 20, 100, 131);
        reset = 1;
        pixel(110, 210, 1, 1);
        model_clear(0);
        reset = 0;
        check_zero_outputs("reset_mid");
        end_frame("reset_mid_fe");
    endtask

    task automatic test_enable();
        rearm();
        set_ball(0, 100, 200, 1);
        hit_pixels(0, 20, 100, 131);
        end_frame("enable_pre");
        enable = 0;
        model_clear(1);
        set_ball(1, 200, 200, 1);
        hit_pixels(1, 20, 200, 231);
        end_frame("enable_low");
        checks++;
        if (last_seen !== 4'b0000) $display("FAIL enable_low_exact: got %b want 0000", last_seen);
        else passed++;
        enable = 1;
    endtask

    task automatic test_random();
        rearm();
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < N; i++)
                set_ball(i, int'($urandom_range(639, 0)), int'($urandom_range(479, 0)),
                         bit'($urandom_range(3, 0) != 0));
            for (int k = 0; k < int'($urandom_range(60, 10)); k++) begin
                int b;
                b = int'($urandom_range(N - 1, 0));
                if ($urandom_range(15, 0) == 0)
                    set_ball(b, m_bx[b], m_by[b], ~m_bv[b]);
                if ($urandom_range(4, 0) == 0)
                    pixel(int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)), 1, 1);
                else
                    pixel(m_bx[b] + int'($urandom_range(BS, 0)) - 1,
                          m_by[b] + int'($urandom_range(BS - 1, 0)),
                          bit'($urandom_range(9, 0) != 0), bit'($urandom_range(3, 0) != 0));
            end
            end_frame("random");
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_below_thresh();
        test_cooldown();
        test_multi();
        test_speed();
        test_edge();
        test_reset_mid();
        test_enable();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
